// File: rtl/menu_video_timing_if.sv
// menu_video_timing_if: mode inputs and raster outputs of the menu video timing generator
interface menu_video_timing_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic pal, scandoubler;
  logic ce_pix, hblank, vblank, hsync, vsync, de, frame_start, field;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc, vc_native, scroll;
  modport master (
    input  pal, scandoubler,
    output ce_pix, hc, vc, vc_native, hblank, vblank, hsync, vsync, de, frame_start, scroll, field
  );
  modport slave (
    output pal, scandoubler,
    input  ce_pix, hc, vc, vc_native, hblank, vblank, hsync, vsync, de, frame_start, scroll, field
  );
endinterface

// File: rtl/menu_video_timing.sv
// menu_video_timing: raster timing generator (pixel CE, h/v counters, sync/blank/DE, per-frame scroll)
// MENU_VT_INTERLACE_EN enables alternating L/L+1 line fields on native (non-scandoubled) output.
module menu_video_timing #(
  parameter int HW          = 10,
  parameter int VW          = 10,
  parameter int CE_DIV      = 2,
  parameter int H_TOTAL     = 640,
  parameter int H_ACTIVE    = 550,
  parameter int H_SS        = 570,
  parameter int H_SE        = 602,
  parameter int NTSC_LINES  = 262,
  parameter int PAL_LINES   = 312,
  parameter int SCROLL_STEP = 6
) (
  input logic clk_sys,
  input logic reset,
  menu_video_timing_if.master vt
);
  localparam int CW = CE_DIV > 1 ? $clog2(CE_DIV) : 1;
  localparam int DS = CE_DIV / 2 > 1 ? CE_DIV / 2 : 1;
  logic [CW-1:0] cnt_q, cnt_d, d_max;
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d, vcn_q, scroll_q, scroll_d, l_max, act, vss, vse, vc_eff;
  logic pal_q, pal_d, sd_q, sd_d, field_q, field_d, ce_q, ce_d;
  logic h_end, v_end, wrap, sc_en;
  logic hblank_q, vblank_q, hsync_q, vsync_q, de_q, fs_q;
  logic hblank_d, vblank_d, hsync_d, vsync_d;
  // Everything below is derived from next-state counters so decodes line up with hc/vc.
  always_comb begin
    d_max = sd_q ? CW'(DS - 1) : CW'(CE_DIV - 1);
    cnt_d = cnt_q >= d_max ? '0 : cnt_q + 1'b1;
    ce_d = cnt_d == d_max;
    l_max = ((pal_q ? VW'(PAL_LINES) : VW'(NTSC_LINES)) << sd_q) - VW'(1) + VW'(field_q);
    h_end = hc_q >= HW'(H_TOTAL - 1);
    v_end = vc_q >= l_max;
    wrap = ce_d & h_end & v_end;
    hc_d = !ce_d ? hc_q : h_end ? '0 : hc_q + 1'b1;
    vc_d = !(ce_d & h_end) ? vc_q : v_end ? '0 : vc_q + 1'b1;
    pal_d = wrap ? vt.pal : pal_q;
    sd_d = wrap ? vt.scandoubler : sd_q;
`ifdef MENU_VT_INTERLACE_EN
    field_d = sd_d ? 1'b0 : field_q ^ wrap;
    sc_en = sd_q | field_q;
`else
    field_d = 1'b0;
    sc_en = 1'b1;
`endif
    scroll_d = wrap & sc_en ? scroll_q + VW'(SCROLL_STEP) : scroll_q;
    act = (pal_d ? VW'(300) : VW'(240)) << sd_d;
    vss = (pal_d ? VW'(304) : VW'(245)) << sd_d;
    vse = (pal_d ? VW'(308) : VW'(248)) << sd_d;
    // odd field: the first half of each line still counts as the previous line for vsync
    vc_eff = vc_d - VW'(field_d & (hc_d < HW'(H_TOTAL / 2)));
    hblank_d = hc_d >= HW'(H_ACTIVE);
    hsync_d = hc_d >= HW'(H_SS) && hc_d < HW'(H_SE);
    vblank_d = vc_d >= act;
    vsync_d = vc_eff >= vss && vc_eff < vse;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
      ce_q <= 1'b0;
      hc_q <= '0;
      vc_q <= '0;
      vcn_q <= '0;
      pal_q <= vt.pal;
      sd_q <= vt.scandoubler;
      field_q <= 1'b0;
      {hblank_q, vblank_q, hsync_q, vsync_q, de_q, fs_q} <= '0;
      scroll_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ce_q <= ce_d;
      hc_q <= hc_d;
      vc_q <= vc_d;
      vcn_q <= vc_d >> sd_d;
      pal_q <= pal_d;
      sd_q <= sd_d;
      field_q <= field_d;
      {hblank_q, vblank_q, hsync_q, vsync_q} <= {hblank_d, vblank_d, hsync_d, vsync_d};
      de_q <= ~(hblank_d | vblank_d);
      fs_q <= wrap;
      scroll_q <= scroll_d;
    end
  end
  assign vt.ce_pix = ce_q;
  assign vt.hc = hc_q;
  assign vt.vc = vc_q;
  assign vt.vc_native = vcn_q;
  assign vt.hblank = hblank_q;
  assign vt.vblank = vblank_q;
  assign vt.hsync = hsync_q;
  assign vt.vsync = vsync_q;
  assign vt.de = de_q;
  assign vt.frame_start = fs_q;
  assign vt.scroll = scroll_q;
  assign vt.field = field_q;
endmodule

// File: tb/tb_menu_video_timing.sv
// tb_menu_video_timing: directed checks of the timing generator with a short line length
module tb_menu_video_timing;
  localparam int LIM = 12000;
  logic clk = 1'b0;
  logic rst, rst_s;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  menu_video_timing_if #(.HW(10), .VW(10)) m ();
  menu_video_timing_if #(.HW(10), .VW(10)) s ();
  menu_video_timing #(
    .HW(10), .VW(10), .CE_DIV(2), .H_TOTAL(16), .H_ACTIVE(12), .H_SS(13), .H_SE(15),
    .NTSC_LINES(262), .PAL_LINES(312), .SCROLL_STEP(6)
  ) u_dut (.clk_sys(clk), .reset(rst), .vt(m));
  menu_video_timing #(
    .HW(10), .VW(10), .CE_DIV(1), .H_TOTAL(1), .H_ACTIVE(1), .H_SS(1), .H_SE(1),
    .NTSC_LINES(262), .PAL_LINES(312), .SCROLL_STEP(6)
  ) u_scr (.clk_sys(clk), .reset(rst_s), .vt(s));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic wait_hv(input int h, input int v);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(m.ce_pix && int'(m.hc) == h && int'(m.vc) == v) && t < LIM);
    check($sformatf("reach_h%0d_v%0d", h, v), 32'(m.ce_pix && int'(m.hc) == h && int'(m.vc) == v), 1);
  endtask
  task automatic wait_fs(output int c);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!m.frame_start && t < LIM);
    check("fs_seen", 32'(m.frame_start), 1);
    c = cyc;
  endtask
  initial begin
    rst = 1'b1;
    rst_s = 1'b1;
    m.pal = 1'b0;
    m.scandoubler = 1'b0;
    s.pal = 1'b0;
    s.scandoubler = 1'b0;
    fork
      begin : main_seq
        int c0, c1;
        logic [3:0] ce4;
        repeat (2) @(negedge clk);
        check("rst_flags", 32'({m.ce_pix, m.hblank, m.vblank, m.hsync, m.vsync, m.de, m.frame_start, m.field}), 0);
        check("rst_hv", 32'({m.hc, m.vc}), 0);
        check("rst_scroll", 32'(m.scroll), 0);
        rst = 1'b0;
        ce4 = '0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); ce4 = {ce4[2:0], m.ce_pix}; end
        check("ce_native", 32'(ce4), 4'b1010);
        wait_hv(11, 0); check("h11_blank_sync", 32'({m.hblank, m.hsync}), 2'b00);
        wait_hv(12, 0); check("h12_blank_sync", 32'({m.hblank, m.hsync}), 2'b10);
        wait_hv(13, 0); check("h13_blank_sync", 32'({m.hblank, m.hsync}), 2'b11);
        wait_hv(14, 0); check("h14_blank_sync", 32'({m.hblank, m.hsync}), 2'b11);
        wait_hv(15, 0); check("h15_blank_sync", 32'({m.hblank, m.hsync}), 2'b10);
        wait_hv(0, 1); check("de_active", 32'({m.hblank, m.vblank, m.de}), 3'b001);
        wait_hv(15, 239); check("v239_vblank_de", 32'({m.vblank, m.de}), 2'b00);
        wait_hv(0, 240); check("v240_vblank_de", 32'({m.vblank, m.de}), 2'b10);
        wait_hv(15, 244); check("v244_vsync", 32'(m.vsync), 0);
        wait_hv(0, 245); check("v245_vsync", 32'(m.vsync), 1);
        wait_hv(15, 247); check("v247_vsync", 32'(m.vsync), 1);
        wait_hv(0, 248); check("v248_vsync", 32'(m.vsync), 0);
        wait_fs(c0);
        check("fs_at_origin", 32'({m.ce_pix, m.hc, m.vc}), 32'({1'b1, 10'd0, 10'd0}));
        check("scroll_f1", 32'(m.scroll), 6);
        @(negedge clk); check("fs_one_cycle", 32'(m.frame_start), 0);
        wait_fs(c1);
        check("ntsc_period", c1 - c0, 8384);
        check("scroll_f2", 32'(m.scroll), 12);
        wait_hv(0, 100);
        m.pal = 1'b1;
        wait_fs(c0);
        check("toggle_frame_ntsc", c0 - c1, 8384);
        wait_hv(0, 262);
        wait_hv(15, 299); check("pal_v299_vblank", 32'(m.vblank), 0);
        wait_hv(0, 300); check("pal_v300_vblank", 32'(m.vblank), 1);
        m.scandoubler = 1'b1;
        wait_fs(c1);
        check("pal_period", c1 - c0, 9984);
        for (int i = 0; i < 4; i++) begin @(negedge clk); ce4 = {ce4[2:0], m.ce_pix}; end
        check("ce_doubled", 32'(ce4), 4'b1111);
        wait_hv(15, 599); check("sd_v599_vblank", 32'(m.vblank), 0);
        wait_hv(0, 600);
        check("sd_v600_vblank", 32'(m.vblank), 1);
        check("sd_vc_native", 32'(m.vc_native), 300);
        check("sd_field", 32'(m.field), 0);
        wait_hv(15, 607); check("sd_v607_vsync", 32'(m.vsync), 0);
        wait_hv(0, 608); check("sd_v608_vsync", 32'(m.vsync), 1);
        wait_hv(15, 615); check("sd_v615_vsync", 32'(m.vsync), 1);
        wait_hv(0, 616); check("sd_v616_vsync", 32'(m.vsync), 0);
        wait_fs(c0);
        check("sd_period", c0 - c1, 9984);
        wait_hv(8, 150);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hv", 32'({m.hc, m.vc}), 0);
        check("midrst_flags", 32'({m.ce_pix, m.hblank, m.vblank, m.hsync, m.vsync, m.de, m.frame_start}), 0);
        check("midrst_scroll", 32'(m.scroll), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst", 32'({m.ce_pix, m.frame_start, m.hc, m.vc}), 32'({1'b1, 1'b0, 10'd1, 10'd0}));
      end
      begin : scr_seq
        int t, c1;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        c1 = 0;
        for (int n = 1; n <= 200; n++) begin
          t = 0;
          do begin @(negedge clk); t++; end
          while (!s.frame_start && t < 400);
          if (!s.frame_start) begin check("scr_fs_seen", 32'(s.frame_start), 1); break; end
          if (n == 1) begin c1 = cyc; check("scr_step1", 32'(s.scroll), 6); end
          if (n == 2) check("scr_period", cyc - c1, 262);
          if (n == 170) check("scr_f170", 32'(s.scroll), 1020);
          if (n == 171) check("scr_wrap_f171", 32'(s.scroll), 2);
          if (n == 200) check("scr_f200", 32'(s.scroll), 176);
        end
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
